// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default sizing for the unified-memory port arbiter.
// WORD_SIZE default mirrors the CPU's word width.
package mem_port_arbiter_pkg;

   localparam int DEFAULT_WORD_SIZE        = 16;
   localparam int DEFAULT_MEM_LATENCY      = 2;
   localparam int DEFAULT_DMA_STARVE_LIMIT = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } arbState_t;

   typedef enum logic {
      OWNER_CPU = 1'b0,
      OWNER_DMA = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between the CPU and a DMA requester,
// sequencing a fixed-latency access and returning read data with a one-cycle ack.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int WORD_SIZE        = DEFAULT_WORD_SIZE,
   parameter int MEM_LATENCY      = DEFAULT_MEM_LATENCY,
   parameter int DMA_STARVE_LIMIT = DEFAULT_DMA_STARVE_LIMIT
)
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [WORD_SIZE-1:0] cpu_addr,
   input  logic [WORD_SIZE-1:0] cpu_wdata,
   output logic [WORD_SIZE-1:0] cpu_rdata,
   output logic                 cpu_ack,
   input  logic                 dma_req,
   input  logic                 dma_we,
   input  logic [WORD_SIZE-1:0] dma_addr,
   input  logic [WORD_SIZE-1:0] dma_wdata,
   output logic [WORD_SIZE-1:0] dma_rdata,
   output logic                 dma_ack,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [WORD_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata
);

   localparam int LAT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int WAIT_W = $clog2(DMA_STARVE_LIMIT + 1);
   localparam logic [LAT_W-1:0]  LAT_LAST   = LAT_W'(MEM_LATENCY - 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(DMA_STARVE_LIMIT);

   arbState_t            state;
   arbState_t            stateNext;
   logic [LAT_W-1:0]     latCnt;
   logic [WAIT_W-1:0]    dmaWait;
   owner_t               owner;
   logic                 ownerWe;
   logic [WORD_SIZE-1:0] ownerAddr;
   logic [WORD_SIZE-1:0] ownerWdata;
   logic [WORD_SIZE-1:0] cpuRdataReg;
   logic [WORD_SIZE-1:0] dmaRdataReg;

   logic                 grantDma;
   logic                 grantCpu;
   logic                 anyGrant;
   logic                 lastCycle;

   function automatic logic [WAIT_W-1:0] satInc(input logic [WAIT_W-1:0] v);
      return (v == WAIT_LIMIT) ? v : v + 1'b1;
   endfunction

   // CPU wins by default; a DMA that has lost DMA_STARVE_LIMIT times takes the port.
   always_comb begin
      grantDma  = 1'b0;
      grantCpu  = 1'b0;
      anyGrant  = 1'b0;
      lastCycle = 1'b0;
      if (state == ST_IDLE) begin
         grantDma = dma_req && (!cpu_req || (dmaWait == WAIT_LIMIT));
         grantCpu = cpu_req && !grantDma;
         anyGrant = grantDma || grantCpu;
      end
      if (state == ST_ACCESS) begin
         lastCycle = (latCnt == LAT_LAST);
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         ST_IDLE:   if (anyGrant)  stateNext = ST_ACCESS;
         ST_ACCESS: if (lastCycle) stateNext = ST_DONE;
         ST_DONE:   stateNext = ST_IDLE;
         default:   stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         latCnt <= '0;
      end else if ((state == ST_ACCESS) && !lastCycle) begin
         latCnt <= latCnt + 1'b1;
      end else begin
         latCnt <= '0;
      end
   end

   // Counts CPU wins that happen while DMA is waiting.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dmaWait <= '0;
      end else if (grantDma) begin
         dmaWait <= '0;
      end else if (grantCpu && dma_req) begin
         dmaWait <= satInc(dmaWait);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         owner   <= OWNER_CPU;
         ownerWe <= 1'b0;
      end else if (anyGrant) begin
         owner   <= grantDma ? OWNER_DMA : OWNER_CPU;
         ownerWe <= grantDma ? dma_we : cpu_we;
      end
   end

   // Address/data are qualified by state, so they need no reset.
   always_ff @(posedge clk) begin
      if (anyGrant) begin
         ownerAddr  <= grantDma ? dma_addr  : cpu_addr;
         ownerWdata <= grantDma ? dma_wdata : cpu_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cpuRdataReg <= '0;
         dmaRdataReg <= '0;
      end else if (lastCycle) begin
         if (owner == OWNER_CPU) begin
            cpuRdataReg <= ownerWe ? '0 : mem_rdata;
         end else begin
            dmaRdataReg <= ownerWe ? '0 : mem_rdata;
         end
      end
   end

   always_comb begin
      mem_read  = (state == ST_ACCESS) && !ownerWe;
      mem_write = (state == ST_ACCESS) && ownerWe;
      mem_addr  = (state == ST_ACCESS) ? ownerAddr : '0;
      mem_wdata = ((state == ST_ACCESS) && ownerWe) ? ownerWdata : '0;
      cpu_ack   = (state == ST_DONE) && (owner == OWNER_CPU);
      dma_ack   = (state == ST_DONE) && (owner == OWNER_DMA);
      cpu_rdata = cpuRdataReg;
      dma_rdata = dmaRdataReg;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory behind the port.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [15:0] cpu_rdata, dma_rdata;
   logic        cpu_ack, dma_ack;
   logic        mem_read, mem_write;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   bit   [15:0] mem [0:255];
   logic        preloadEn;
   logic [7:0]  preloadAddr;
   logic [15:0] preloadData;

   int tests = 0;
   int fails = 0;
   int strobeOverlap = 0;
   int ackOverlap = 0;

   mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(2), .DMA_STARVE_LIMIT(3)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem_read ? mem[mem_addr[7:0]] : 16'h0000;

   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
      else if (preloadEn) mem[preloadAddr] <= preloadData;
   end

   always @(negedge clk) begin
      if (mem_read && mem_write) strobeOverlap++;
      if (cpu_ack && dma_ack) ackOverlap++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [15:0] d);
      preloadAddr = a;
      preloadData = d;
      preloadEn   = 1'b1;
      tick();
      preloadEn   = 1'b0;
   endtask

   // Drives one CPU transaction; ackCyc is the cycle of cpu_ack counted from request (1), -1 on timeout.
   task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                             output logic [15:0] rdata, output int ackCyc);
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
      ackCyc = -1; rdata = 16'hxxxx;
      for (int c = 1; c <= 12; c++) begin
         if (cpu_ack) begin
            ackCyc = c;
            rdata  = cpu_rdata;
            break;
         end
         tick();
      end
      cpu_req = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
      preloadEn = 0; preloadAddr = 0; preloadData = 0;
      tick();
      preload(8'h10, 16'hBEEF);
      preload(8'h01, 16'hA001);
      preload(8'h02, 16'hA002);
      tests++; if ({cpu_ack, dma_ack} !== 2'b00) begin fails++; $display("FAIL reset_acks: got %b need 00", {cpu_ack, dma_ack}); end
      tests++; if ({mem_read, mem_write} !== 2'b00) begin fails++; $display("FAIL reset_strobes: got %b need 00", {mem_read, mem_write}); end
      tests++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin fails++; $display("FAIL reset_mem_bus: got addr %h wdata %h need 0 0", mem_addr, mem_wdata); end
      tests++; if (cpu_rdata !== 16'h0 || dma_rdata !== 16'h0) begin fails++; $display("FAIL reset_rdata: got %h %h need 0 0", cpu_rdata, dma_rdata); end
      tests++; if (dut.dmaWait !== 2'd0) begin fails++; $display("FAIL reset_dma_wait: got %0d need 0", dut.dmaWait); end
      reset_n = 1'b1;
      tick();
      tests++; if ({cpu_ack, dma_ack, mem_read, mem_write} !== 4'b0000) begin fails++; $display("FAIL idle_no_req: got %b need 0000", {cpu_ack, dma_ack, mem_read, mem_write}); end
   endtask

   task automatic test_cpu_read();
      cpu_we = 0; cpu_addr = 16'h0010; cpu_req = 1;
      tests++; if (mem_read !== 1'b0 || cpu_ack !== 1'b0) begin fails++; $display("FAIL rd_c1: got rd %b ack %b need 0 0", mem_read, cpu_ack); end
      tick();
      tests++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 16'h0010) begin fails++; $display("FAIL rd_c2: got rd %b wr %b addr %h need 1 0 0010", mem_read, mem_write, mem_addr); end
      tick();
      tests++; if (mem_read !== 1'b1 || mem_addr !== 16'h0010 || cpu_ack !== 1'b0) begin fails++; $display("FAIL rd_c3: got rd %b addr %h ack %b need 1 0010 0", mem_read, mem_addr, cpu_ack); end
      tick();
      tests++; if (cpu_ack !== 1'b1 || cpu_rdata !== 16'hBEEF) begin fails++; $display("FAIL rd_c4_ack: got ack %b rdata %h need 1 BEEF", cpu_ack, cpu_rdata); end
      tests++; if (mem_read !== 1'b0 || dma_ack !== 1'b0) begin fails++; $display("FAIL rd_c4_quiet: got rd %b dma_ack %b need 0 0", mem_read, dma_ack); end
      cpu_req = 0;
      tick();
      tests++; if (cpu_ack !== 1'b0 || cpu_rdata !== 16'hBEEF) begin fails++; $display("FAIL rd_c5_hold: got ack %b rdata %h need 0 BEEF", cpu_ack, cpu_rdata); end
   endtask

   task automatic test_dma_write();
      logic [15:0] r;
      int          ac;
      dma_we = 1; dma_addr = 16'h0020; dma_wdata = 16'h1234; dma_req = 1;
      tick();
      tests++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 16'h0020 || mem_wdata !== 16'h1234) begin fails++; $display("FAIL wr_c2: got wr %b rd %b addr %h data %h need 1 0 0020 1234", mem_write, mem_read, mem_addr, mem_wdata); end
      tick();
      tests++; if (mem_write !== 1'b1 || mem_addr !== 16'h0020) begin fails++; $display("FAIL wr_c3: got wr %b addr %h need 1 0020", mem_write, mem_addr); end
      tick();
      tests++; if (dma_ack !== 1'b1 || cpu_ack !== 1'b0 || dma_rdata !== 16'h0) begin fails++; $display("FAIL wr_c4_ack: got dma_ack %b cpu_ack %b rdata %h need 1 0 0000", dma_ack, cpu_ack, dma_rdata); end
      tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL wr_c4_strobe: got %b need 0", mem_write); end
      dma_req = 0; dma_we = 0;
      tick();
      cpu_access(1'b0, 16'h0020, 16'h0, r, ac);
      tests++; if (r !== 16'h1234 || ac !== 4) begin fails++; $display("FAIL wr_readback: got %h at cycle %0d need 1234 at 4", r, ac); end
   endtask

   task automatic test_starvation();
      logic       seq  [8];
      logic [1:0] wantWait [8];
      logic       wantSeq  [8];
      int         n = 0;
      wantWait = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      wantSeq  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      cpu_we = 0; cpu_addr = 16'h0010; cpu_req = 1;
      dma_we = 0; dma_addr = 16'h0020; dma_req = 1;
      for (int c = 1; c <= 40 && n < 8; c++) begin
         if (cpu_ack || dma_ack) begin
            seq[n] = dma_ack;
            tests++; if (dut.dmaWait !== wantWait[n]) begin fails++; $display("FAIL starve_wait_%0d: got %0d need %0d", n, dut.dmaWait, wantWait[n]); end
            n++;
         end
         if (n == 8) begin
            cpu_req = 0; dma_req = 0;
         end
         tick();
      end
      tests++; if (n !== 8) begin fails++; $display("FAIL starve_count: got %0d acks need 8", n); end
      for (int i = 0; i < n; i++) begin
         tests++; if (seq[i] !== wantSeq[i]) begin fails++; $display("FAIL starve_order_%0d: got owner %0d need %0d", i, seq[i], wantSeq[i]); end
      end
      cpu_req = 0; dma_req = 0;
      tick();
   endtask

   task automatic test_simultaneous();
      int          cpuC = -1, dmaC = -1, cpuN = 0, dmaN = 0;
      logic [15:0] cpuR = 0, dmaR = 0;
      cpu_we = 0; cpu_addr = 16'h0010; cpu_req = 1;
      dma_we = 0; dma_addr = 16'h0020; dma_req = 1;
      for (int c = 1; c <= 10; c++) begin
         if (cpu_ack) begin cpuC = c; cpuR = cpu_rdata; cpuN++; cpu_req = 0; end
         if (dma_ack) begin dmaC = c; dmaR = dma_rdata; dmaN++; dma_req = 0; end
         tick();
      end
      tests++; if (cpuC !== 4 || cpuN !== 1) begin fails++; $display("FAIL sim_cpu_first: got cycle %0d count %0d need 4 1", cpuC, cpuN); end
      tests++; if (dmaC !== 8 || dmaN !== 1) begin fails++; $display("FAIL sim_dma_next: got cycle %0d count %0d need 8 1", dmaC, dmaN); end
      tests++; if (cpuR !== 16'hBEEF || dmaR !== 16'h1234) begin fails++; $display("FAIL sim_rdata: got %h %h need BEEF 1234", cpuR, dmaR); end
      tests++; if (dut.dmaWait !== 2'd0) begin fails++; $display("FAIL sim_wait_clear: got %0d need 0", dut.dmaWait); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] r;
      int          ac;
      cpu_we = 1; cpu_addr = 16'h0030; cpu_wdata = 16'h5555; cpu_req = 1;
      tick();
      tests++; if (mem_write !== 1'b1) begin fails++; $display("FAIL rst_c2: got wr %b need 1", mem_write); end
      tick();
      tests++; if (mem_write !== 1'b1 || mem_addr !== 16'h0030) begin fails++; $display("FAIL rst_c3: got wr %b addr %h need 1 0030", mem_write, mem_addr); end
      reset_n = 0;
      tick();
      tests++; if ({mem_read, mem_write, cpu_ack, dma_ack} !== 4'b0000 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin fails++; $display("FAIL rst_outputs: got strobes/acks %b addr %h data %h need 0000 0 0", {mem_read, mem_write, cpu_ack, dma_ack}, mem_addr, mem_wdata); end
      tests++; if (cpu_rdata !== 16'h0 || dma_rdata !== 16'h0) begin fails++; $display("FAIL rst_rdata: got %h %h need 0 0", cpu_rdata, dma_rdata); end
      cpu_req = 0; reset_n = 1;
      tick();
      tests++; if (cpu_ack !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("FAIL rst_no_ack: got ack %b wr %b need 0 0", cpu_ack, mem_write); end
      cpu_access(1'b1, 16'h0030, 16'h5555, r, ac);
      tests++; if (ac !== 4 || r !== 16'h0) begin fails++; $display("FAIL rst_reissue: got cycle %0d rdata %h need 4 0000", ac, r); end
      cpu_access(1'b0, 16'h0030, 16'h0, r, ac);
      tests++; if (ac !== 4 || r !== 16'h5555) begin fails++; $display("FAIL rst_readback: got cycle %0d rdata %h need 4 5555", ac, r); end
   endtask

   task automatic test_back_to_back();
      int          a1 = -1, a2 = -1;
      logic [15:0] r1 = 0, r2 = 0;
      cpu_we = 0; cpu_addr = 16'h0001; cpu_req = 1;
      for (int c = 1; c <= 14; c++) begin
         if (cpu_ack) begin
            if (a1 < 0) begin
               a1 = c; r1 = cpu_rdata; cpu_addr = 16'h0002;
            end else begin
               a2 = c; r2 = cpu_rdata; cpu_req = 0;
               tick();
               break;
            end
         end
         tick();
      end
      cpu_req = 0;
      tests++; if (a1 !== 4 || r1 !== 16'hA001) begin fails++; $display("FAIL b2b_first: got cycle %0d rdata %h need 4 A001", a1, r1); end
      tests++; if (a2 - a1 !== 4 || r2 !== 16'hA002) begin fails++; $display("FAIL b2b_second: got gap %0d rdata %h need 4 A002", a2 - a1, r2); end
      tests++; if (strobeOverlap !== 0) begin fails++; $display("FAIL strobe_overlap: got %0d cycles need 0", strobeOverlap); end
      tests++; if (ackOverlap !== 0) begin fails++; $display("FAIL ack_overlap: got %0d cycles need 0", ackOverlap); end
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_dma_write();
      test_starvation();
      test_simultaneous();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
